// File: rtl/maxunpool_2x2_stream_if.sv
// Stream bundle for the 2x2 unpool stage: pooled input side and full-res output side.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface maxunpool_2x2_stream_if #(
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic [1:0]                   in_idx;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_last;

    modport slave (
        input  in_valid, in_data, in_idx, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_idx, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/maxunpool_2x2_stream.sv
// Streaming 2x2 unpool/upsample with a one-row replay buffer.
// Define UNPOOL_ARGMAX_EN for max-unpool (argmax routing); default is nearest-neighbour.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module maxunpool_2x2_stream #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int IN_W       = 4,
    parameter int IN_H       = 4
) (
    input logic                  clk,
    input logic                  rst,
    maxunpool_2x2_stream_if.slave bus
);
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

    typedef enum logic {S_EVEN, S_ODD} state_t;

    state_t                       state, state_n;
    logic [CW-1:0]                col, col_n;
    logic [RW-1:0]                row, row_n;
    logic                         dup, dup_n;
    logic                         ov, ov_n;
    logic                         ol, ol_n;
    logic signed [DATA_WIDTH-1:0] od, od_n;
    logic                         rdy;
    logic                         lb_we;
    logic                         slot_free;
    logic signed [DATA_WIDTH-1:0] cand_in;
    logic signed [DATA_WIDTH-1:0] cand_buf;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic signed [DATA_WIDTH-1:0] lb_data [IN_W];

    assign slot_free = !ov || bus.out_ready;
    assign rd_data   = lb_data[col];

`ifdef UNPOOL_ARGMAX_EN
    logic [1:0] lb_idx [IN_W];
    logic [1:0] rd_idx;

    assign rd_idx = lb_idx[col];
    // Buffer copies sit at {dy,dx} = {in S_ODD, dup}
    assign cand_in  = (bus.in_idx == 2'b00) ? bus.in_data : '0;
    assign cand_buf = (rd_idx == {state == S_ODD, dup}) ? rd_data : '0;
`else
    logic unused_idx;

    assign unused_idx = ^bus.in_idx;
    assign cand_in    = bus.in_data;
    assign cand_buf   = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_data[col] <= bus.in_data;
`ifdef UNPOOL_ARGMAX_EN
            lb_idx[col]  <= bus.in_idx;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EVEN;
            col   <= '0;
            row   <= '0;
            dup   <= 1'b0;
            ov    <= 1'b0;
            od    <= '0;
            ol    <= 1'b0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            dup   <= dup_n;
            ov    <= ov_n;
            od    <= od_n;
            ol    <= ol_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        dup_n   = dup;
        ov_n    = ov && !bus.out_ready;
        ol_n    = ol && !bus.out_ready;
        od_n    = od;
        rdy     = 1'b0;
        lb_we   = 1'b0;
        unique case (state)
            S_EVEN: begin
                if (!dup) begin
                    rdy = slot_free && !rst;
                    if (bus.in_valid && rdy) begin
                        lb_we = 1'b1;
                        ov_n  = 1'b1;
                        od_n  = cand_in;
                        ol_n  = 1'b0;
                        dup_n = 1'b1;
                    end
                end else if (slot_free) begin
                    ov_n  = 1'b1;
                    od_n  = cand_buf;
                    ol_n  = 1'b0;
                    dup_n = 1'b0;
                    if (col == COL_LAST) begin
                        col_n   = '0;
                        state_n = S_ODD;
                    end else begin
                        col_n = col + 1'b1;
                    end
                end
            end
            S_ODD: begin
                if (slot_free) begin
                    ov_n  = 1'b1;
                    od_n  = cand_buf;
                    ol_n  = dup && (col == COL_LAST) && (row == ROW_LAST);
                    dup_n = !dup;
                    if (dup) begin
                        if (col == COL_LAST) begin
                            col_n   = '0;
                            state_n = S_EVEN;
                            row_n   = (row == ROW_LAST) ? '0 : row + 1'b1;
                        end else begin
                            col_n = col + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign bus.out_last  = ol;
endmodule

// File: tb/tb_maxunpool_2x2_stream.sv
// Directed bench for maxunpool_2x2_stream at IN_W=2, IN_H=2, 8-bit data.
// Expectations follow UNPOOL_ARGMAX_EN the same way as the design.
module tb_maxunpool_2x2_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;

    maxunpool_2x2_stream_if #(.DATA_WIDTH(8)) bus ();

    maxunpool_2x2_stream #(
        .DATA_WIDTH(8),
        .IN_W      (2),
        .IN_H      (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int ir_bad   = 0;
    int stall_bad = 0;
    int cyc      = 0;
    int n_out    = 0;
    bit rand_rdy = 1'b0;
    logic hold_rdy = 1'b1;
    bit prev_stall = 1'b0;
    logic signed [7:0] prev_d;
    logic prev_l;

    logic signed [7:0] got_d[$];
    logic              got_l[$];
    int                got_c[$];

    always @(negedge clk)
        bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;

    // Output capture plus in_ready / stall-stability watchdogs
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            n_out = 0;
            prev_stall = 1'b0;
            if (bus.in_ready !== 1'b0) ir_bad++;
        end else begin
            if (bus.in_ready === 1'b1 &&
                ((n_out + int'(bus.out_valid)) % 8) != 0 &&
                ((n_out + int'(bus.out_valid)) % 8) != 2)
                ir_bad++;
            if (prev_stall && !(bus.out_valid === 1'b1 &&
                bus.out_data === prev_d && bus.out_last === prev_l))
                stall_bad++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d = bus.out_data;
            prev_l = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(bus.out_data);
                got_l.push_back(bus.out_last);
                got_c.push_back(cyc);
                n_out++;
            end
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following acceptance
    task automatic send(input int d, input int ix);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(d);
        bus.in_idx   = 2'(ix);
        for (int t = 0; t < 400 && !acc; t++) begin
            #1;
            acc = bus.in_ready;
            @(negedge clk);
        end
        chk("send_accept", 32'(acc), 1);
    endtask

    task automatic send_frame(input int d[4], input int ix[4]);
        for (int i = 0; i < 4; i++) send(d[i], ix[i]);
    endtask

    task automatic wait_n(input int n);
        for (int t = 0; t < 600 && got_d.size() < n; t++) @(negedge clk);
        chk("out_count", got_d.size(), n);
    endtask

    function automatic int exp_out(input int d[4], input int ix[4], input int k);
        int r  = k / 8;
        int dy = (k / 4) % 2;
        int c  = (k / 2) % 2;
        int dx = k % 2;
        int s  = d[r*2 + c];
`ifdef UNPOOL_ARGMAX_EN
        return (ix[r*2 + c] == dy*2 + dx) ? s : 0;
`else
        int unused_ix = ix[0];
        return s + 0 * unused_ix;
`endif
    endfunction

    task automatic check_frame(input string tag, input int d[4], input int ix[4],
                               input int base);
        for (int k = 0; k < 16; k++) begin
            if (got_d.size() > base + k) begin
                chk($sformatf("%s_d%0d", tag, k), got_d[base+k], exp_out(d, ix, k));
                chk($sformatf("%s_l%0d", tag, k), 32'(got_l[base+k]), (k == 15) ? 1 : 0);
            end
        end
    endtask

    function automatic void clear_q();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endfunction

    int t1_d[4]  = '{5, -3, 7, 1};
    int t1_i[4]  = '{0, 3, 1, 2};
    int r_d[4]   = '{9, 8, 6, 4};
    int r_i[4]   = '{0, 1, 2, 3};
    int b0_d[4]  = '{1, 2, 3, 4};
    int b0_i[4]  = '{3, 2, 1, 0};
    int b1_d[4]  = '{-8, -7, 100, -128};
    int b1_i[4]  = '{0, 0, 3, 1};
`ifdef UNPOOL_ARGMAX_EN
    int t1_exp[16] = '{5, 0, 0, 0, 0, 0, 0, -3, 0, 7, 0, 0, 0, 0, 1, 0};
`else
    int t1_exp[16] = '{5, 5, -3, -3, 5, 5, -3, -3, 7, 7, 1, 1, 7, 7, 1, 1};
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_idx   = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data",  bus.out_data, 0);
        chk("rst_out_last",  32'(bus.out_last), 0);
        chk("rst_in_ready",  32'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(bus.in_ready), 1);
        @(negedge clk);

        // Directed frame, out_ready held high
        clear_q();
        send_frame(t1_d, t1_i);
        bus.in_valid = 1'b0;
        wait_n(16);
        for (int k = 0; k < 16 && k < got_d.size(); k++) begin
            chk($sformatf("t1_d%0d", k), got_d[k], t1_exp[k]);
            chk($sformatf("t1_l%0d", k), 32'(got_l[k]), (k == 15) ? 1 : 0);
        end
        repeat (4) @(negedge clk);

        // Same frame under random back-pressure
        clear_q();
        rand_rdy = 1'b1;
        send_frame(t1_d, t1_i);
        bus.in_valid = 1'b0;
        wait_n(16);
        check_frame("t3", t1_d, t1_i, 0);
        rand_rdy = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_no_extra", got_d.size(), 16);
        chk("stall_stable", stall_bad, 0);

        // Abort a frame with reset, then send a fresh one
        clear_q();
        send(5, 0);
        send(-3, 3);
        bus.in_valid = 1'b0;
        wait_n(3);
        rst = 1'b1;
        clear_q();
        repeat (2) @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_out_last", 32'(bus.out_last), 0);
        rst = 1'b0;
        send_frame(r_d, r_i);
        bus.in_valid = 1'b0;
        wait_n(16);
        check_frame("rst", r_d, r_i, 0);
        repeat (4) @(negedge clk);

        // Two back-to-back frames, in_valid never dropped
        clear_q();
        send_frame(b0_d, b0_i);
        send_frame(b1_d, b1_i);
        bus.in_valid = 1'b0;
        wait_n(32);
        check_frame("b2b0", b0_d, b0_i, 0);
        check_frame("b2b1", b1_d, b1_i, 16);
        if (got_c.size() >= 32)
            chk("b2b_span", got_c[31] - got_c[0], 31);
        repeat (4) @(negedge clk);

        chk("in_ready_mon", ir_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/maxunpool_2x2_stream.md
# maxunpool_2x2_stream

Streaming 2x2 unpool / upsample: the inverse-direction counterpart of the 2x2 max-pool stage. Consumes a raster-order stream of pooled samples (IN_W x IN_H) and emits a raster-order stream of the full-resolution map (2·IN_W x 2·IN_H). It sits on decoder / upsampling paths, between a feature-map buffer and the next conv stage. A one-row line buffer replays each pooled row for the second output row.

## Interface
- DATA_WIDTH, default `DATA_WIDTH (cnn_params.vh): signed sample width
- IN_W, default 4: pooled row width in samples, ≥1
- IN_H, default 4: pooled rows per frame, ≥1
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  pooled sample present
- in_ready  output  1  block accepts sample this cycle
- in_data  input  DATA_WIDTH (signed)  pooled sample
- in_idx  input  2  argmax position {dy,dx} (used only with UNPOOL_ARGMAX_EN)
- out_valid  output  1  output sample present
- out_ready  input  1  downstream accepts
- out_data  output  DATA_WIDTH (signed)  full-res sample
- out_last  output  1  high with final sample of frame

## Operation
- Transfer on either side occurs when valid && ready on a rising edge.
- States: S_EVEN (emitting output row 2r from live input), S_ODD (emitting row 2r+1 from line buffer).
- Counters: col (0..IN_W-1), row (0..IN_H-1), dup bit (0 = first copy / dx=0, 1 = second copy / dx=1).
- S_EVEN, dup=0: in_ready = !out_valid || out_ready. On accept, store {in_data,in_idx} in line buffer[col]; load output register with copy dx=0; dup←1.
- S_EVEN, dup=1: in_ready=0; when output slot frees, load copy dx=1 of the same sample; dup←0; col++. After col=IN_W-1 → S_ODD, col←0.
- S_ODD: in_ready=0; emit buffer[col] twice (dx=0, dx=1), one per free output slot; after col=IN_W-1 second copy → S_EVEN, col←0, row++ (wraps to 0 after IN_H-1).
- out_last set on the dx=1 copy of col=IN_W-1 in S_ODD with row=IN_H-1.
- Output register holds out_data/out_valid/out_last stable while out_valid && !out_ready.
- Width: no arithmetic on data; out_data is DATA_WIDTH, a pass-through or zero.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, state=S_EVEN, col=row=dup=0. in_ready=0 while rst is high, and 1 on the first cycle after reset.
- Latency: an input accepted at edge N appears on out_data after edge N (dx=0 copy). The dx=1 copy follows on the first edge at which the dx=0 copy is consumed.
- Throughput: one output per cycle with out_ready held high. Input duty is 1 sample per 4 output cycles on average: 2 cycles in S_EVEN per sample, then the whole row is replayed in S_ODD.
- Back-pressure (out_ready=0) freezes all counters and state; in_ready drops once the output register is full.
- in_valid=0 in S_EVEN: no output is generated and the pipeline idles. No bubble is inserted in the S_ODD replay.
- Reset asserted mid-frame discards the partial frame; the next accepted input is treated as frame sample (0,0).
- Frame boundary: after out_last is consumed, the next frame's first input may be accepted on the same edge.

## Configuration
- UNPOOL_ARGMAX_EN defined: max-unpool. The line buffer also stores in_idx. The output for sub-position {dy,dx} (dy=0 in S_EVEN, 1 in S_ODD) is the sample if in_idx=={dy,dx}, else 0.
- Undefined: nearest-neighbour upsample. Every sub-position outputs the sample. in_idx is ignored and not stored, and the buffer holds DATA_WIDTH bits per entry.

## Test plan
- IN_W=2, IN_H=2, out_ready=1, inputs 5,-3,7,1 (macro off) -> outputs 5,5,-3,-3, 5,5,-3,-3, 7,7,1,1, 7,7,1,1; out_last only on the 16th output.
- Same inputs with idx 0,3,1,2 (macro on) -> 5,0,0,0, 0,0,0,-3, 0,7,0,0, 0,0,1,0.
- Random out_ready toggling (≈50%) on the first test -> identical sequence. out_data and out_last are stable while stalled, and no sample is lost or duplicated.
- in_ready monitor -> in_ready=0 throughout every S_ODD replay and on every dup=1 cycle; never high during rst.
- rst pulsed after 3 outputs of frame 1, then a full frame of 9,8,6,4 sent -> output starts 9,9,8,8 with no stale data from the aborted frame.
- Two back-to-back frames with in_valid held high -> 32 outputs with out_last on the 16th and 32nd, and no idle cycle between frames.
